// File: rtl/mii_rx_framer_if.sv
// MII receive framer signal bundle: PHY-side nibble stream in, MAC-side
// byte stream and per-frame status out. The framer uses the master view.
interface mii_rx_framer_if;
  // PHY side
  logic        phy_rx_dv;
  logic [3:0]  phy_rxd;
  logic        phy_rx_err;
  // MAC side
  logic [7:0]  rx_mac_data;
  logic        rx_mac_valid;
  logic        rx_mac_last;
  logic        rx_mac_err;
  logic        rx_stat_valid;
  logic [26:0] rx_stat_vector;

  modport master (
    input  phy_rx_dv, phy_rxd, phy_rx_err,
    output rx_mac_data, rx_mac_valid, rx_mac_last, rx_mac_err,
           rx_stat_valid, rx_stat_vector
  );

  modport slave (
    output phy_rx_dv, phy_rxd, phy_rx_err,
    input  rx_mac_data, rx_mac_valid, rx_mac_last, rx_mac_err,
           rx_stat_valid, rx_stat_vector
  );
endinterface

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles nibbles into bytes,
// flags the final byte, checks the Ethernet FCS and reports a per-frame
// status vector. Everything runs on phy_rx_clk; all outputs are registered.
module mii_rx_framer #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic            phy_rx_clk,
  input  logic            reset,
  mii_rx_framer_if.master bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

  // Good-frame residue C704DD7B as it appears in an LSB-first (reflected)
  // shift register, i.e. bit-reversed.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [1:0]  state;
  logic        prev_dv;     // dv on the previous cycle, to spot a fresh carrier
  logic        odd;         // a low nibble is waiting for its high nibble
  logic [3:0]  low_nib;
  logic [7:0]  hold_byte;   // last completed byte, released once its successor completes
  logic        hold_valid;
  logic [15:0] byte_cnt;
  logic [31:0] crc;
  logic        err_seen;
  logic        bcast;       // every DA byte seen so far was FF
  logic        mcast;

  logic [7:0]  cur_byte;
  logic [31:0] crc_next;
  logic [26:0] frame_stat;

  // One byte through the reflected CRC-32 (polynomial 04C11DB7 reversed).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // Byte being completed this cycle, its CRC update, and the status vector
  // that would be reported if the frame ended now.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cur_byte   = {bus.phy_rxd, low_nib};
    crc_next   = crc32_byte(crc, cur_byte);
    frame_stat = '0;
    frame_stat[15:0] = byte_cnt;
    frame_stat[16]   = (crc != CRC_RESIDUE);
    frame_stat[17]   = (byte_cnt < MIN_LEN);
    frame_stat[18]   = (byte_cnt > MAX_LEN);
    frame_stat[19]   = err_seen;
    frame_stat[20]   = odd;
    // A short DA counts its missing bytes as 0, so it cannot be broadcast.
    frame_stat[21]   = bcast && (byte_cnt >= 16'd6);
    frame_stat[22]   = mcast;
  end

  // Framing FSM, byte assembly, FCS/length tracking and output registers.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge phy_rx_clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      // Treat the line as busy until an idle cycle is seen, so a frame
      // already in flight at reset release is dropped rather than parsed.
      prev_dv    <= 1'b1;
      odd        <= 1'b0;
      low_nib    <= '0;
      hold_byte  <= '0;
      hold_valid <= 1'b0;
      byte_cnt   <= '0;
      crc        <= '0;
      err_seen   <= 1'b0;
      bcast      <= 1'b0;
      mcast      <= 1'b0;
      bus.rx_mac_data    <= '0;
      bus.rx_mac_valid   <= 1'b0;
      bus.rx_mac_last    <= 1'b0;
      bus.rx_mac_err     <= 1'b0;
      bus.rx_stat_valid  <= 1'b0;
      bus.rx_stat_vector <= '0;
    end else begin
      prev_dv           <= bus.phy_rx_dv;
      bus.rx_mac_valid  <= 1'b0;
      bus.rx_mac_last   <= 1'b0;
      bus.rx_mac_err    <= 1'b0;
      bus.rx_stat_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.phy_rx_dv) begin
            if (bus.phy_rxd == 4'h5 && !prev_dv) state <= S_PREAMBLE;
            else                                 state <= S_DROP;
          end
        end

        S_PREAMBLE: begin
          if (!bus.phy_rx_dv) begin
            state <= S_IDLE;
          end else if (bus.phy_rxd == 4'hD) begin
            // SFD: start a fresh frame context.
            state      <= S_DATA;
            odd        <= 1'b0;
            hold_valid <= 1'b0;
            byte_cnt   <= '0;
            crc        <= 32'hFFFFFFFF;
            err_seen   <= 1'b0;
            bcast      <= 1'b1;
            mcast      <= 1'b0;
          end else if (bus.phy_rxd != 4'h5) begin
            state <= S_DROP;
          end
        end

        S_DATA: begin
          if (bus.phy_rx_dv) begin
            if (bus.phy_rx_err) err_seen <= 1'b1;
            if (!odd) begin
              low_nib <= bus.phy_rxd;
              odd     <= 1'b1;
            end else begin
              odd        <= 1'b0;
              hold_byte  <= cur_byte;
              hold_valid <= 1'b1;
              crc        <= crc_next;
              if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
              if (byte_cnt < 16'd6 && cur_byte != 8'hFF) bcast <= 1'b0;
              if (byte_cnt == 16'd0) mcast <= cur_byte[0];
              // The previous byte is now known not to be the last one.
              if (hold_valid) begin
                bus.rx_mac_valid <= 1'b1;
                bus.rx_mac_data  <= hold_byte;
              end
            end
          end else begin
            // End of carrier: close the frame; a dangling nibble is dropped.
            state              <= S_IDLE;
            odd                <= 1'b0;
            bus.rx_stat_valid  <= 1'b1;
            bus.rx_stat_vector <= frame_stat;
            if (hold_valid) begin
              bus.rx_mac_valid <= 1'b1;
              bus.rx_mac_last  <= 1'b1;
              bus.rx_mac_data  <= hold_byte;
              bus.rx_mac_err   <= |frame_stat[20:16];
            end
          end
        end

        default: begin  // S_DROP
          if (!bus.phy_rx_dv) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: builds Ethernet frames with a locally
// computed FCS, drives them as MII nibbles and checks the byte stream and
// status vectors against hand-derived values.
module tb_mii_rx_framer;

  logic phy_rx_clk = 1'b0;
  logic reset;

  mii_rx_framer_if bus ();

  mii_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .phy_rx_clk (phy_rx_clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 phy_rx_clk = ~phy_rx_clk;

  localparam logic [47:0] DA_UNI   = 48'hd2345678aabb;
  localparam logic [47:0] DA_BCAST = 48'hffffffffffff;
  localparam logic [47:0] DA_MCAST = 48'h01005e000001;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  rx_q[$];
  int          last_cnt, last_pos, stat_cnt, proto_bad;
  logic        last_err;
  logic [26:0] stat_vec;
  int          mark_bytes, mark_stat;

  // Output monitor, sampling on the falling edge.
  always @(negedge phy_rx_clk) begin
    if (bus.rx_mac_valid) rx_q.push_back(bus.rx_mac_data);
    if (bus.rx_mac_last) begin
      last_cnt++;
      last_pos = rx_q.size();
      last_err = bus.rx_mac_err;
      if (!bus.rx_mac_valid || !bus.rx_stat_valid) proto_bad++;
    end
    if (bus.rx_mac_err && !bus.rx_mac_last) proto_bad++;
    if (bus.rx_stat_valid) begin
      stat_cnt++;
      stat_vec = bus.rx_stat_vector;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {25'd0, bus.rx_mac_valid, bus.rx_mac_last, bus.rx_mac_err,
            bus.rx_stat_valid, bus.rx_mac_data, bus.rx_stat_vector};
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ d[b]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // DA, fixed SA, patterned payload, then FCS (optionally one bit flipped).
  task automatic build_frame(input logic [47:0] da, input int len, input bit bad_fcs);
    logic [31:0] c;
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(da[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(8'(8'h10 + i));
    for (int i = 12; i < len - 4; i++) frame_q.push_back(8'(i*37 + 11));
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frame_q.size(); i++) c = crc_upd(c, frame_q[i]);
    c = ~c;
    if (bad_fcs) c = c ^ 32'h0000_0100;
    frame_q.push_back(c[7:0]);
    frame_q.push_back(c[15:8]);
    frame_q.push_back(c[23:16]);
    frame_q.push_back(c[31:24]);
  endtask

  task automatic nib(input logic [3:0] d, input logic er);
    @(negedge phy_rx_clk);
    bus.phy_rx_dv  = 1'b1;
    bus.phy_rxd    = d;
    bus.phy_rx_err = er;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge phy_rx_clk);
      bus.phy_rx_dv  = 1'b0;
      bus.phy_rxd    = 4'h0;
      bus.phy_rx_err = 1'b0;
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    last_cnt  = 0;
    last_pos  = 0;
    last_err  = 1'b0;
    stat_cnt  = 0;
    proto_bad = 0;
  endtask

  // 7 preamble nibbles + SFD + frame_q; optional trailing nibble, PHY error
  // on one byte, and a reset window between two byte indices.
  task automatic send_frame(input bit extra, input int err_at, input int rst_at, input int rst_end);
    for (int i = 0; i < 7; i++) nib(4'h5, 1'b0);
    nib(4'hD, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      nib(frame_q[i][3:0], 1'(i == err_at));
      if (i == rst_at) begin
        #2 reset = 1'b0;
        #1 check("outputs_in_reset", outs(), 64'd0);
        mark_bytes = rx_q.size();
        mark_stat  = stat_cnt;
      end
      if (i == rst_end) #2 reset = 1'b1;
      nib(frame_q[i][7:4], 1'(i == err_at));
    end
    if (extra) nib(4'h9, 1'b0);
    idle(8);
  endtask

  task automatic check_frame(input string tag, input int len, input logic [26:0] vec, input logic err);
    int mm;
    mm = 0;
    for (int i = 0; i < rx_q.size() && i < frame_q.size(); i++)
      if (rx_q[i] !== frame_q[i]) mm++;
    check({tag, "_bytes"},     64'(rx_q.size()), 64'(len));
    check({tag, "_data"},      64'(mm),          64'd0);
    check({tag, "_last_cnt"},  64'(last_cnt),    (len != 0) ? 64'd1 : 64'd0);
    check({tag, "_last_pos"},  64'(last_pos),    64'(len));
    check({tag, "_err"},       64'(last_err),    64'(err));
    check({tag, "_stat_cnt"},  64'(stat_cnt),    64'd1);
    check({tag, "_vector"},    64'(stat_vec),    64'(vec));
    check({tag, "_protocol"},  64'(proto_bad),   64'd0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.phy_rx_dv  = 1'b0;
    bus.phy_rxd    = 4'h0;
    bus.phy_rx_err = 1'b0;
    clear_mon();
    #12 check("reset_outputs", outs(), 64'd0);
    @(negedge phy_rx_clk) reset = 1'b1;
    idle(4);

    // Good 64-byte unicast frame.
    clear_mon(); build_frame(DA_UNI, 64, 1'b0); send_frame(1'b0, -1, -1, -1);
    check_frame("good64", 64, 27'h0000040, 1'b0);

    // Same frame with one FCS bit flipped.
    clear_mon(); build_frame(DA_UNI, 64, 1'b1); send_frame(1'b0, -1, -1, -1);
    check_frame("badfcs", 64, 27'h0010040, 1'b1);

    // 40-byte broadcast: runt, broadcast, multicast.
    clear_mon(); build_frame(DA_BCAST, 40, 1'b0); send_frame(1'b0, -1, -1, -1);
    check_frame("bcast40", 40, 27'h0620028, 1'b1);

    // Good 64-byte frame plus a dangling nibble.
    clear_mon(); build_frame(DA_UNI, 64, 1'b0); send_frame(1'b1, -1, -1, -1);
    check_frame("dribble", 64, 27'h0100040, 1'b1);

    // Multicast, not broadcast: flag only, frame still good.
    clear_mon(); build_frame(DA_MCAST, 64, 1'b0); send_frame(1'b0, -1, -1, -1);
    check_frame("mcast64", 64, 27'h0400040, 1'b0);

    // Length boundaries.
    clear_mon(); build_frame(DA_UNI, 63, 1'b0); send_frame(1'b0, -1, -1, -1);
    check_frame("runt63", 63, 27'h002003F, 1'b1);
    clear_mon(); build_frame(DA_UNI, 1518, 1'b0); send_frame(1'b0, -1, -1, -1);
    check_frame("max1518", 1518, 27'h00005EE, 1'b0);
    clear_mon(); build_frame(DA_UNI, 1519, 1'b0); send_frame(1'b0, -1, -1, -1);
    check_frame("long1519", 1519, 27'h00405EF, 1'b1);

    // SFD immediately followed by end of carrier: status only.
    clear_mon(); frame_q.delete(); send_frame(1'b0, -1, -1, -1);
    check_frame("empty", 0, 27'h0030000, 1'b0);

    // PHY error at byte 20 of a 100-byte frame.
    clear_mon(); build_frame(DA_UNI, 100, 1'b0); send_frame(1'b0, 20, -1, -1);
    check_frame("phyerr100", 100, 27'h0080064, 1'b1);

    // Broken preamble 5,5,A followed by data: dropped silently.
    clear_mon();
    nib(4'h5, 1'b0); nib(4'h5, 1'b0); nib(4'hA, 1'b0);
    for (int i = 0; i < 12; i++) nib(4'(i), 1'b0);
    idle(8);
    check("badpre_bytes", 64'(rx_q.size()), 64'd0);
    check("badpre_stat",  64'(stat_cnt),    64'd0);

    // Reset asserted at byte 30, released at byte 35: rest of frame dropped.
    clear_mon(); build_frame(DA_UNI, 64, 1'b0); send_frame(1'b0, -1, 30, 35);
    check("rst_bytes_after", 64'(rx_q.size()), 64'(mark_bytes));
    check("rst_stat_after",  64'(stat_cnt),    64'(mark_stat));
    check("rst_last_cnt",    64'(last_cnt),    64'd0);

    // Next good frame is received normally.
    clear_mon(); build_frame(DA_UNI, 64, 1'b0); send_frame(1'b0, -1, -1, -1);
    check_frame("post_rst", 64, 27'h0000040, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
